// File: rtl/rssb_pkg.sv
// Shared types and defaults for the RSSB controller.
// Holds the FSM state encoding and parameter defaults.
package rssb_pkg;

    localparam int WIDTH_D = 8;
    localparam logic [7:0] HALT_OP_D = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READ,
        S_WRITE,
        S_HALT
    } state_t;

endpackage

// File: rtl/rssb_sub.sv
// Unsigned subtractor a - b with borrow-out.
// Borrow is set exactly when a < b.
module rssb_sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             borrow
);

    logic [WIDTH:0] w_diff;

    // One extra bit catches the borrow of the unsigned difference
    always_comb begin
        w_diff = {1'b0, a} - {1'b0, b};
        result = w_diff[WIDTH-1:0];
        borrow = w_diff[WIDTH];
    end

endmodule

// File: rtl/rssb_ctrl.sv
// Reverse-subtract-skip-if-borrow single-instruction CPU controller.
// Each instruction takes FETCH, READ and WRITE cycles.
module rssb_ctrl
    import rssb_pkg::*;
#(
    parameter int               WIDTH   = WIDTH_D,
    parameter logic [WIDTH-1:0] HALT_OP = WIDTH'(HALT_OP_D)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] ram_addr,
    output logic             ram_write,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] acc_o,
    output logic [15:0]      icount
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_result;
    logic             r_borrow;
    logic [15:0]      r_icount;
    logic [WIDTH-1:0] w_res;
    logic             w_borrow;
    logic [WIDTH-1:0] w_step;

    rssb_sub #(.WIDTH(WIDTH)) u_sub (
        .a      (ram_rdata),
        .b      (r_acc),
        .result (w_res),
        .borrow (w_borrow)
    );

    assign w_step   = r_borrow ? WIDTH'(2) : WIDTH'(1);
    assign rom_addr = r_pc;
    assign pc_o     = r_pc;
    assign acc_o    = r_acc;
    assign icount   = r_icount;

    // All architectural and FSM state, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_result <= '0;
            r_borrow <= 1'b0;
            r_icount <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_pc     <= '0;
                        r_acc    <= '0;
                        r_icount <= '0;
                    end
                end
                S_FETCH: begin
                    if (rom_data != HALT_OP) r_opnd <= rom_data;
                end
                S_READ: begin
                    r_result <= w_res;
                    r_borrow <= w_borrow;
                end
                S_WRITE: begin
                    r_acc    <= r_result;
                    r_pc     <= r_pc + w_step;
                    r_icount <= r_icount + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Next-state: start only matters when not executing
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: w_next = (rom_data == HALT_OP) ? S_HALT : S_READ;
            S_READ:  w_next = S_WRITE;
            S_WRITE: w_next = S_FETCH;
            S_HALT:  if (start) w_next = S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded purely from the current state
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        ram_write = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (r_state)
            S_FETCH: busy = 1'b1;
            S_READ: begin
                busy     = 1'b1;
                ram_addr = r_opnd;
            end
            S_WRITE: begin
                busy      = 1'b1;
                ram_write = 1'b1;
                ram_addr  = r_opnd;
                ram_wdata = r_result;
            end
            S_HALT:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rssb_ctrl.sv
// Self-checking bench for rssb_ctrl with ROM/RAM models.
// A program interpreter predicts every output cycle.
module tb_rssb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr, rom_data;
    logic [7:0]  ram_addr, ram_wdata, ram_rdata;
    logic        ram_write, busy, done;
    logic [7:0]  pc_o, acc_o;
    logic [15:0] icount;

    logic [7:0] rom  [256];
    logic [7:0] ram  [256];
    logic [7:0] mram [256];

    int checks = 0;
    int errors = 0;
    logic wr_seen = 1'b0;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        wr;
        logic [7:0]  rom_a;
        logic [7:0]  ram_a;
        logic [7:0]  wd;
        logic [7:0]  pc;
        logic [7:0]  acc;
        logic [15:0] ic;
    } rec_t;

    rec_t q[$];
    rec_t hold = '0;
    rec_t e;

    rssb_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_addr  (ram_addr),
        .ram_write (ram_write),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy),
        .done      (done),
        .pc_o      (pc_o),
        .acc_o     (acc_o),
        .icount    (icount)
    );

    always #5 clk = ~clk;

    assign rom_data  = rom[rom_addr];
    assign ram_rdata = ram[ram_addr];

    always @(posedge clk) begin
        if (ram_write) begin
            ram[ram_addr] <= ram_wdata;
            wr_seen <= 1'b1;
        end
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic rec_t mk(logic b, logic d, logic w,
                                logic [7:0] ra, logic [7:0] ma,
                                logic [7:0] wd, logic [7:0] pc,
                                logic [7:0] acc, logic [15:0] ic);
        rec_t r;
        r.busy = b; r.done = d; r.wr = w;
        r.rom_a = ra; r.ram_a = ma; r.wd = wd;
        r.pc = pc; r.acc = acc; r.ic = ic;
        return r;
    endfunction

    // Interpret the whole program into a per-cycle trace
    task automatic build();
        logic [7:0]  pc, acc, op, r;
        logic        b;
        logic [15:0] ic;
        pc = 0; acc = 0; ic = 0;
        for (int n = 0; n < 600; n++) begin
            op = rom[pc];
            q.push_back(mk(1, 0, 0, pc, 0, 0, pc, acc, ic));
            if (op == 8'hFF) break;
            q.push_back(mk(1, 0, 0, pc, op, 0, pc, acc, ic));
            b = mram[op] < acc;
            r = mram[op] - acc;
            q.push_back(mk(1, 0, 1, pc, op, r, pc, acc, ic));
            mram[op] = r;
            acc = r;
            pc = pc + (b ? 8'd2 : 8'd1);
            ic = ic + 16'd1;
        end
        hold = mk(0, 1, 0, pc, 0, 0, pc, acc, ic);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            hold = '0;
        end else if (q.size() > 0) begin
            void'(q.pop_front());
        end else if (start) begin
            build();
        end
    end

    always @(negedge clk) begin
        e = (q.size() > 0) ? q[0] : hold;
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("ram_write", 32'(ram_write), 32'(e.wr));
        chk("rom_addr", 32'(rom_addr), 32'(e.rom_a));
        chk("ram_addr", 32'(ram_addr), 32'(e.ram_a));
        chk("ram_wdata", 32'(ram_wdata), 32'(e.wd));
        chk("pc_o", 32'(pc_o), 32'(e.pc));
        chk("acc_o", 32'(acc_o), 32'(e.acc));
        chk("icount", 32'(icount), 32'(e.ic));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load(input logic [7:0] fill);
        for (int i = 0; i < 256; i++) begin
            rom[i] = fill;
            ram[i] = 8'h00;
            mram[i] = 8'h00;
        end
    endtask

    task automatic setram(input logic [7:0] a, input logic [7:0] v);
        ram[a] = v;
        mram[a] = v;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int bound, input string n);
        for (int i = 0; i < bound && done !== 1'b1; i++) tick();
        chk(n, 32'(done), 32'd1);
    endtask

    task automatic wait_pc(input logic [7:0] v, input int bound,
                           input logic eq, input string n);
        for (int i = 0; i < bound && ((pc_o === v) != eq); i++) tick();
        chk(n, 32'(pc_o === v), 32'(eq));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        load(8'hFF);
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pc", 32'(pc_o), 32'd0);
        rst = 1'b1;
        tick();

        // single instruction then halt
        load(8'hFF);
        rom[0] = 8'h80;
        setram(8'h80, 8'h01);
        pulse();
        tick();
        tick();
        chk("t1_wr", 32'(ram_write), 32'd1);
        chk("t1_addr", 32'(ram_addr), 32'h80);
        chk("t1_wdata", 32'(ram_wdata), 32'h01);
        tick();
        chk("t1_acc", 32'(acc_o), 32'h01);
        chk("t1_pc", 32'(pc_o), 32'h01);
        chk("t1_ic", 32'(icount), 32'd1);
        wait_done(20, "t1_done");
        chk("t1_ram", 32'(ram[8'h80]), 32'h01);

        // borrow skip, start pulsed during READ
        do_reset();
        load(8'hFF);
        rom[0] = 8'h82;
        rom[1] = 8'h81;
        setram(8'h82, 8'h05);
        setram(8'h81, 8'h02);
        pulse();
        tick();
        tick();
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_wdata", 32'(ram_wdata), 32'hFD);
        chk("t2_addr", 32'(ram_addr), 32'h81);
        tick();
        chk("t2_acc", 32'(acc_o), 32'hFD);
        chk("t2_pc", 32'(pc_o), 32'h03);
        chk("t2_ic", 32'(icount), 32'd2);
        wait_done(20, "t2_done");
        chk("t2_ram", 32'(ram[8'h81]), 32'hFD);

        // restart from HALT without reset
        pulse();
        chk("t2r_busy", 32'(busy), 32'd1);
        chk("t2r_pc0", 32'(pc_o), 32'd0);
        wait_done(40, "t2r_done");
        chk("t2r_pc", 32'(pc_o), 32'h02);
        chk("t2r_acc", 32'(acc_o), 32'hF8);
        chk("t2r_ic", 32'(icount), 32'd2);

        // immediate halt, never writes
        do_reset();
        load(8'hFF);
        wr_seen = 1'b0;
        pulse();
        chk("t3_busy", 32'(busy), 32'd1);
        tick();
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_busy2", 32'(busy), 32'd0);
        tick();
        chk("t3_nowr", 32'(wr_seen), 32'd0);

        // pc wrap FF -> 00 without borrow
        do_reset();
        load(8'h20);
        pulse();
        wait_pc(8'hFF, 1000, 1'b1, "t4_reach");
        wait_pc(8'hFF, 10, 1'b0, "t4_leave");
        chk("t4_pc", 32'(pc_o), 32'h00);
        chk("t4_ic", 32'(icount), 32'h100);

        // pc wrap FF -> 01 with borrow
        do_reset();
        load(8'h20);
        rom[8'hFE] = 8'h25;
        rom[8'hFF] = 8'h26;
        setram(8'h25, 8'h03);
        setram(8'h26, 8'h01);
        pulse();
        wait_pc(8'hFF, 1000, 1'b1, "t5_reach");
        wait_pc(8'hFF, 10, 1'b0, "t5_leave");
        chk("t5_pc", 32'(pc_o), 32'h01);
        chk("t5_acc", 32'(acc_o), 32'hFE);
        chk("t5_ic", 32'(icount), 32'h100);

        // asynchronous reset in WRITE
        do_reset();
        load(8'hFF);
        rom[0] = 8'h80;
        setram(8'h80, 8'h01);
        pulse();
        tick();
        tick();
        chk("t6_inwr", 32'(ram_write), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_wr", 32'(ram_write), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_addr", 32'(ram_addr), 32'd0);
        chk("t6_wdata", 32'(ram_wdata), 32'd0);
        chk("t6_pc", 32'(pc_o), 32'd0);
        chk("t6_acc", 32'(acc_o), 32'd0);
        chk("t6_ic", 32'(icount), 32'd0);
        tick();
        chk("t6_ram", 32'(ram[8'h80]), 32'h01);
        load(8'hFF);
        rom[0] = 8'h80;
        setram(8'h80, 8'h01);
        rst = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t7_first", 32'(busy), 32'd1);
        wait_done(20, "t7_done");
        chk("t7_acc", 32'(acc_o), 32'h01);

        tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
